// File: rtl/bus_pkg.sv
// Shared types and default address map for the bus interconnect.
// Slave 0 covers the low 64 KiB, slave 1 one word, slaves 2 and 3 four words each.
package bus_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int DEFAULT_NUM_SLAVES = 4;
    localparam int DEFAULT_ADDR_W     = 32;

    localparam logic [DEFAULT_NUM_SLAVES*DEFAULT_ADDR_W-1:0] DEFAULT_SLAVE_BASE = {
        32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000
    };

    localparam logic [DEFAULT_NUM_SLAVES*DEFAULT_ADDR_W-1:0] DEFAULT_SLAVE_MASK = {
        32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'hFFFF_0000
    };

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester after last_grant_i, wrapping.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_grant_i,
    output logic [$clog2(N)-1:0] grant_o,
    output logic                 valid_o
);

    localparam int IDX_W = $clog2(N);

    int cand;

    // Search starts one past the previous winner, so the previous winner is checked last.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_grant_i) + k) % N;
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                grant_o = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/bus_interconnect.sv
// Multi-master, multi-slave shared bus: round-robin arbitration, address decode,
// per-transaction timeout and abort on request withdrawal.
module bus_interconnect
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 255,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEFAULT_SLAVE_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEFAULT_SLAVE_MASK
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
    input  logic [NUM_MASTERS-1:0]          m_read,
    input  logic [NUM_MASTERS-1:0]          m_write,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_write_mask,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_write_value,
    output logic [NUM_MASTERS*DATA_W-1:0]   m_read_value,
    output logic [NUM_MASTERS-1:0]          m_ready,
    output logic [NUM_MASTERS-1:0]          m_error,
    output logic [NUM_SLAVES-1:0]           s_sel,
    output logic [ADDR_W-1:0]               s_address,
    output logic                            s_read,
    output logic                            s_write,
    output logic [DATA_W/8-1:0]             s_write_mask,
    output logic [DATA_W-1:0]               s_write_value,
    input  logic [NUM_SLAVES*DATA_W-1:0]    s_read_value,
    input  logic [NUM_SLAVES-1:0]           s_ready
);

    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int STRB_W = DATA_W / 8;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   wait_q, wait_d;

    logic [NUM_MASTERS-1:0] masterReq;
    logic [IDX_W-1:0]       arbGrant;
    logic                   arbValid;
    int                     grantIdx;

    logic [ADDR_W-1:0]  grantAddr;
    logic               grantRead;
    logic               grantWrite;
    logic [STRB_W-1:0]  grantMask;
    logic [DATA_W-1:0]  grantWdata;

    logic               hitAny;
    int                 selIdx;
    logic               selReady;
    logic [DATA_W-1:0]  selRdata;

    assign masterReq = m_read | m_write;
    assign grantIdx  = int'(grant_q);

    // grant_q doubles as last_grant: it is only rewritten when a new grant is made.
    rr_arbiter #(
        .N(NUM_MASTERS)
    ) u_arbiter (
        .req_i        (masterReq),
        .last_grant_i (grant_q),
        .grant_o      (arbGrant),
        .valid_o      (arbValid)
    );

    assign grantAddr  = m_address[grantIdx*ADDR_W +: ADDR_W];
    assign grantRead  = m_read[grant_q];
    assign grantWrite = m_write[grant_q];
    assign grantMask  = m_write_mask[grantIdx*STRB_W +: STRB_W];
    assign grantWdata = m_write_value[grantIdx*DATA_W +: DATA_W];

    // Lowest-index hit wins when windows overlap.
    always_comb begin
        hitAny = 1'b0;
        selIdx = 0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hitAny &&
                ((grantAddr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W])) begin
                hitAny = 1'b1;
                selIdx = i;
            end
        end
    end

    assign selReady = s_ready[selIdx];
    assign selRdata = s_read_value[selIdx*DATA_W +: DATA_W];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        wait_d        = wait_q;
        s_sel         = '0;
        s_address     = '0;
        s_read        = 1'b0;
        s_write       = 1'b0;
        s_write_mask  = '0;
        s_write_value = '0;
        m_ready       = '0;
        m_error       = '0;
        m_read_value  = '0;

        case (state_q)
            IDLE: begin
                if (arbValid) begin
                    grant_d = arbGrant;
                    wait_d  = '0;
                    state_d = ACTIVE;
                end
            end

            ACTIVE: begin
                if (!(grantRead || grantWrite)) begin
                    state_d = IDLE;
                end else begin
                    s_address     = grantAddr;
                    s_read        = grantRead;
                    s_write       = grantWrite;
                    s_write_mask  = grantMask;
                    s_write_value = grantWdata;
                    if (!hitAny) begin
                        m_ready[grant_q] = 1'b1;
                        m_error[grant_q] = 1'b1;
                        state_d          = IDLE;
                    end else begin
                        s_sel[selIdx] = 1'b1;
                        // A slave answering in the timeout cycle still completes cleanly.
                        if (selReady) begin
                            m_ready[grant_q]                       = 1'b1;
                            m_read_value[grantIdx*DATA_W +: DATA_W] = selRdata;
                            state_d                                = IDLE;
                        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
                            m_ready[grant_q] = 1'b1;
                            m_error[grant_q] = 1'b1;
                            state_d          = IDLE;
                        end else begin
                            wait_d = wait_q + 1'b1;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= IDX_W'(NUM_MASTERS - 1);
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_bus_interconnect.sv
// Self-checking bench for bus_interconnect: directed scenarios plus randomized
// rounds checked against an address-range / round-robin reference model.
module tb_bus_interconnect;

    localparam int NM  = 2;
    localparam int NS  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NM*AW-1:0]       m_address;
    logic [NM-1:0]          m_read;
    logic [NM-1:0]          m_write;
    logic [NM*DW/8-1:0]     m_write_mask;
    logic [NM*DW-1:0]       m_write_value;
    logic [NM*DW-1:0]       m_read_value;
    logic [NM-1:0]          m_ready;
    logic [NM-1:0]          m_error;
    logic [NS-1:0]          s_sel;
    logic [AW-1:0]          s_address;
    logic                   s_read;
    logic                   s_write;
    logic [DW/8-1:0]        s_write_mask;
    logic [DW-1:0]          s_write_value;
    logic [NS*DW-1:0]       s_read_value;
    logic [NS-1:0]          s_ready;

    bus_interconnect #(
        .NUM_MASTERS (NM),
        .NUM_SLAVES  (NS),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT     (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_write_mask  (m_write_mask),
        .m_write_value (m_write_value),
        .m_read_value  (m_read_value),
        .m_ready       (m_ready),
        .m_error       (m_error),
        .s_sel         (s_sel),
        .s_address     (s_address),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_write_mask  (s_write_mask),
        .s_write_value (s_write_value),
        .s_read_value  (s_read_value),
        .s_ready       (s_ready)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: pending request per master and the last granted master.
    bit          pend  [NM];
    logic [31:0] pAddr [NM];
    bit          pWr   [NM];
    logic [3:0]  pMask [NM];
    logic [31:0] pData [NM];
    int          lastGrant;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_m_ready"}, 64'(m_ready), 64'd0);
        checkOutput({tag, "_m_error"}, 64'(m_error), 64'd0);
        checkOutput({tag, "_m_rdata"}, 64'(m_read_value), 64'd0);
        checkOutput({tag, "_s_sel"}, 64'(s_sel), 64'd0);
        checkOutput({tag, "_s_rw"}, 64'({s_read, s_write}), 64'd0);
        checkOutput({tag, "_s_addr"}, 64'(s_address), 64'd0);
    endtask

    // Address map expressed as plain address ranges.
    function automatic int decodeModel(input logic [31:0] a);
        if (a < 32'h0001_0000)                              return 0;
        else if (a >= 32'h0001_0000 && a < 32'h0001_0004)   return 1;
        else if (a >= 32'h0002_0000 && a < 32'h0002_0010)   return 2;
        else if (a >= 32'h0003_0000 && a < 32'h0003_0010)   return 3;
        else                                                return -1;
    endfunction

    function automatic int rrModel();
        for (int k = 1; k <= NM; k++) begin
            if (pend[(lastGrant + k) % NM]) return (lastGrant + k) % NM;
        end
        return -1;
    endfunction

    task automatic newReq(input int m);
        pend[m]  = 1'b1;
        pWr[m]   = 1'($urandom_range(0, 1));
        pMask[m] = 4'($urandom_range(1, 15));
        pData[m] = $urandom;
        case ($urandom_range(0, 5))
            0: pAddr[m] = $urandom_range(0, 32'h0000_FFFF);
            1: pAddr[m] = 32'h0001_0000 + $urandom_range(0, 3);
            2: pAddr[m] = 32'h0002_0000 + $urandom_range(0, 15);
            3: pAddr[m] = 32'h0003_0000 + $urandom_range(0, 15);
            4: pAddr[m] = 32'h0004_0000 + $urandom_range(0, 32'h0000_FFFF);
            default: pAddr[m] = 32'h0001_0004 + $urandom_range(0, 8);
        endcase
    endtask

    task automatic applyStimulus();
        m_address = '0; m_read = '0; m_write = '0; m_write_mask = '0; m_write_value = '0;
        for (int m = 0; m < NM; m++) begin
            m_address[m*AW +: AW]        = pAddr[m];
            m_read[m]                    = pend[m] && !pWr[m];
            m_write[m]                   = pend[m] && pWr[m];
            m_write_mask[m*(DW/8) +: 4]  = pMask[m];
            m_write_value[m*DW +: DW]    = pData[m];
        end
    endtask

    // One arbitration cycle followed by the access cycles of the granted master.
    // readyAt is the ACTIVE cycle in which the addressed slave answers (beyond TMO = never).
    task automatic serveRound(input int readyAt, input logic [31:0] rdata, output int g);
        int          slv;
        bit          done;
        logic [3:0]  expSel;
        logic [1:0]  expReady, expErr;
        logic [63:0] expRv;
        @(negedge clk);
        applyStimulus();
        #1 checkIdle("arb");
        g      = rrModel();
        slv    = decodeModel(pAddr[g]);
        expSel = (slv >= 0) ? (4'b0001 << slv) : 4'b0000;
        done   = 1'b0;
        for (int cyc = 1; cyc <= TMO + 2 && !done; cyc++) begin
            @(negedge clk);
            s_ready      = 4'($urandom);
            s_read_value = {$urandom, $urandom, $urandom, $urandom};
            if (slv >= 0) begin
                s_ready[slv]               = (cyc == readyAt);
                s_read_value[slv*DW +: DW] = rdata;
            end
            #1;
            expReady = '0; expErr = '0; expRv = '0;
            if (slv < 0) begin
                expReady[g] = 1'b1; expErr[g] = 1'b1; done = 1'b1;
            end else if (cyc == readyAt) begin
                expReady[g] = 1'b1; expRv[g*DW +: DW] = rdata; done = 1'b1;
            end else if (cyc == TMO) begin
                expReady[g] = 1'b1; expErr[g] = 1'b1; done = 1'b1;
            end
            checkOutput("s_address", 64'(s_address), 64'(pAddr[g]));
            checkOutput("s_rw", 64'({s_read, s_write}), 64'({!pWr[g], pWr[g]}));
            checkOutput("s_wmask", 64'(s_write_mask), 64'(pMask[g]));
            checkOutput("s_wdata", 64'(s_write_value), 64'(pData[g]));
            checkOutput("s_sel", 64'(s_sel), 64'(expSel));
            checkOutput("m_ready", 64'(m_ready), 64'(expReady));
            checkOutput("m_error", 64'(m_error), 64'(expErr));
            checkOutput("m_rdata", m_read_value, expRv);
        end
        checkOutput("txn_done", 64'(done), 64'd1);
        lastGrant = g;
        pend[g]   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int g;
        reset = 1'b1;
        s_ready = '0; s_read_value = '0;
        for (int m = 0; m < NM; m++) begin
            pend[m] = 1'b0; pAddr[m] = '0; pWr[m] = 1'b0; pMask[m] = '0; pData[m] = '0;
        end
        lastGrant = NM - 1;
        applyStimulus();
        repeat (3) @(negedge clk);
        #1 checkIdle("reset");
        @(negedge clk) reset = 1'b0;

        // Single read from master 0 to slave 0, slave answers in the first access cycle.
        pend[0] = 1'b1; pAddr[0] = 32'h0000_0010; pWr[0] = 1'b0; pMask[0] = 4'hF; pData[0] = '0;
        serveRound(1, 32'hDEADBEEF, g);

        // Unmapped write from master 1 completes with error immediately.
        pend[1] = 1'b1; pAddr[1] = 32'h0005_0000; pWr[1] = 1'b1; pMask[1] = 4'hF; pData[1] = $urandom;
        serveRound(1, $urandom, g);

        // Slave 2 never answers -> timeout; then it answers exactly in the timeout cycle.
        pend[0] = 1'b1; pAddr[0] = 32'h0002_0004; pWr[0] = 1'b0; pMask[0] = 4'hF;
        serveRound(TMO + 1, $urandom, g);
        pend[0] = 1'b1; pAddr[0] = 32'h0002_0004; pWr[0] = 1'b0;
        serveRound(TMO, $urandom, g);

        // Both masters keep requesting: grants must alternate.
        for (int i = 0; i < 6; i++) begin
            for (int m = 0; m < NM; m++) begin
                if (!pend[m]) begin
                    newReq(m);
                    pAddr[m] = $urandom_range(0, 32'h0000_FFFF);
                end
            end
            serveRound(1, $urandom, g);
        end

        // Granted master withdraws its request during the access: no completion.
        pend[0] = 1'b0;
        pend[1] = 1'b1; pAddr[1] = 32'h0003_0008; pWr[1] = 1'b1; pMask[1] = 4'h3; pData[1] = $urandom;
        @(negedge clk);
        applyStimulus();
        s_ready = '0;
        #1 checkIdle("abort_arb");
        g = rrModel();
        @(negedge clk);
        m_read = '0; m_write = '0; s_ready = '1;
        #1;
        checkOutput("abort_m_ready", 64'(m_ready), 64'd0);
        checkOutput("abort_m_error", 64'(m_error), 64'd0);
        checkOutput("abort_s_sel", 64'(s_sel), 64'd0);
        checkOutput("abort_s_write", 64'(s_write), 64'd0);
        lastGrant = g;
        pend[g]   = 1'b0;
        @(negedge clk);
        s_ready = '0;
        #1 checkIdle("abort_after");

        // Reset arriving mid-transaction; then simultaneous requests go to master 0 first.
        pend[0] = 1'b1; pAddr[0] = 32'h0002_0008; pWr[0] = 1'b0; pMask[0] = 4'hF;
        @(negedge clk);
        applyStimulus();
        s_ready = '0;
        #1 g = rrModel();
        @(negedge clk);
        reset = 1'b1;
        #1 checkOutput("rst_sync_s_addr", 64'(s_address), 64'(pAddr[g]));
        @(negedge clk);
        reset = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        applyStimulus();
        #1 checkIdle("rst_mid");
        lastGrant = NM - 1;
        newReq(0);
        newReq(1);
        serveRound($urandom_range(1, TMO + 1), $urandom, g);
        checkOutput("rst_first_grant", 64'(g), 64'd0);

        // Randomized rounds with requests held until served.
        for (int r = 0; r < 40; r++) begin
            for (int m = 0; m < NM; m++) begin
                if (!pend[m] && ($urandom_range(0, 1) == 1)) newReq(m);
            end
            if (!pend[0] && !pend[1]) newReq($urandom_range(0, NM - 1));
            serveRound($urandom_range(1, TMO + 1), $urandom, g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
